// File: rtl/noc_vc_input_port.sv
// ---------------------------------------------------------------------------
// noc_vc_input_port
//
// Virtual-channel input port for the NoC router. Holds NUM_VC independent
// circular flit FIFOs of DEPTH entries each and presents one head flit at a
// time to the crossbar. The presented VC is chosen by round-robin and held
// (locked) while the downstream stalls. Every pop returns a registered
// one-cycle credit for the popped VC. Writes that cannot be stored are
// dropped and raise a sticky overflow flag.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   data_i         incoming flit
//   write_en       flit present on data_i this cycle
//   vc_i           target VC of the incoming flit
//   shift          downstream consumes the presented flit this cycle
//   data_o         head flit of the selected VC (0 when nothing presented)
//   vc_o           VC of the presented flit (0 when nothing presented)
//   read_valid_o   a flit is presented
//   credit_valid_o one-cycle credit-return pulse (registered)
//   credit_vc_o    VC being credited (0 when no credit)
//   count_o        per-VC occupancy, VC k in bits [k*CNT_W +: CNT_W]
//   overflow_o     sticky drop flag, cleared only by rst
// ---------------------------------------------------------------------------
module noc_vc_input_port #(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 5,
  parameter  int NUM_VC = 2,
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    write_en,
  input  logic [VC_W-1:0]         vc_i,
  input  logic                    shift,
  output logic [WIDTH-1:0]        data_o,
  output logic [VC_W-1:0]         vc_o,
  output logic                    read_valid_o,
  output logic                    credit_valid_o,
  output logic [VC_W-1:0]         credit_vc_o,
  output logic [NUM_VC*CNT_W-1:0] count_o,
  output logic                    overflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [VC_W-1:0]  vc_t;

  // Flit storage and per-VC bookkeeping.
  logic [WIDTH-1:0] mem    [NUM_VC][DEPTH];
  ptr_t             rd_ptr [NUM_VC];
  ptr_t             wr_ptr [NUM_VC];
  cnt_t             count  [NUM_VC];

  // Arbitration state.
  vc_t  rr_ptr;
  logic lock;
  vc_t  locked_vc;

  // Combinational decode.
  logic [NUM_VC-1:0] not_empty;
  logic [NUM_VC-1:0] push_v;
  logic [NUM_VC-1:0] pop_v;
  vc_t               grant;
  logic              read_valid;
  logic              pop;
  logic              drop;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // VC following v, wrapping at NUM_VC (always 0 when NUM_VC = 1).
  function automatic vc_t next_vc(input vc_t v);
    return (int'(v) >= NUM_VC - 1) ? '0 : v + vc_t'(1);
  endfunction

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      not_empty[v] = (count[v] != '0);
    end
  end

  // Locked round-robin: a stalled grant is held; otherwise scan from rr_ptr.
  always_comb begin : arbiter
    int   idx;
    logic found;
    // NOTE: every variable written here gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    grant = lock ? locked_vc : '0;
    found = lock;
    idx   = 0;
    // NOTE: blocking assignments are used in combinational logic so the scan
    // sees its own earlier results; sequential state below uses <= only.
    for (int i = 0; i < NUM_VC; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_VC;
      if (!found && not_empty[idx]) begin
        grant = vc_t'(idx);
        found = 1'b1;
      end
    end
  end

  assign read_valid = |not_empty;
  assign pop        = shift && read_valid;

  // A full VC still accepts a write when it is being popped in the same cycle.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      pop_v[v]  = pop && (grant == vc_t'(v));
      push_v[v] = write_en && (vc_i == vc_t'(v)) &&
                  ((count[v] != cnt_t'(DEPTH)) || pop_v[v]);
    end
    // Out-of-range VC or full VC without a matching pop.
    drop = write_en && !(|push_v);
  end

  // Per-VC pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push_v[v]) wr_ptr[v] <= next_ptr(wr_ptr[v]);
        if (pop_v[v])  rd_ptr[v] <= next_ptr(rd_ptr[v]);
        if (push_v[v] && !pop_v[v]) begin
          count[v] <= count[v] + cnt_t'(1);
        end else if (pop_v[v] && !push_v[v]) begin
          count[v] <= count[v] - cnt_t'(1);
        end
      end
    end
  end

  // NOTE: the storage array is not reset; pointers and counts define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (!rst && push_v[v]) mem[v][wr_ptr[v]] <= data_i;
    end
  end

  // Arbitration, credit return and overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      lock           <= 1'b0;
      locked_vc      <= '0;
      credit_valid_o <= 1'b0;
      credit_vc_o    <= '0;
      overflow_o     <= 1'b0;
    end else begin
      if (pop) begin
        rr_ptr         <= next_vc(grant);
        lock           <= 1'b0;
        credit_valid_o <= 1'b1;
        credit_vc_o    <= grant;
      end else begin
        credit_valid_o <= 1'b0;
        credit_vc_o    <= '0;
        // Downstream stalled: hold this VC until it is consumed.
        if (read_valid) begin
          lock      <= 1'b1;
          locked_vc <= grant;
        end
      end
      if (drop) overflow_o <= 1'b1;
    end
  end

  assign read_valid_o = read_valid;
  assign vc_o         = read_valid ? grant : '0;
  assign data_o       = read_valid ? mem[grant][rd_ptr[grant]] : '0;

  for (genvar k = 0; k < NUM_VC; k++) begin : g_count
    assign count_o[k*CNT_W +: CNT_W] = count[k];
  end

endmodule

// File: tb/tb_noc_vc_input_port.sv
// ---------------------------------------------------------------------------
// tb_noc_vc_input_port
//
// Self-checking bench for noc_vc_input_port (WIDTH=16, DEPTH=5, NUM_VC=2).
// Expected presented flits are queued by each scenario when its stimulus is
// driven and compared whenever a pop happens; the credit returned on the
// following cycle is compared against the queued entry's VC.
// ---------------------------------------------------------------------------
module tb_noc_vc_input_port;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 5;
  localparam int NUM_VC = 2;
  localparam int VC_W   = 1;
  localparam int CNT_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [WIDTH-1:0]        data_i;
  logic                    write_en;
  logic [VC_W-1:0]         vc_i;
  logic                    shift;
  logic [WIDTH-1:0]        data_o;
  logic [VC_W-1:0]         vc_o;
  logic                    read_valid_o;
  logic                    credit_valid_o;
  logic [VC_W-1:0]         credit_vc_o;
  logic [NUM_VC*CNT_W-1:0] count_o;
  logic                    overflow_o;

  noc_vc_input_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_i         (data_i),
    .write_en       (write_en),
    .vc_i           (vc_i),
    .shift          (shift),
    .data_o         (data_o),
    .vc_o           (vc_o),
    .read_valid_o   (read_valid_o),
    .credit_valid_o (credit_valid_o),
    .credit_vc_o    (credit_vc_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VC_W-1:0]  vc;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [CNT_W-1:0] cnt(input int k);
    return count_o[k*CNT_W +: CNT_W];
  endfunction

  task automatic expect_flit(input logic [VC_W-1:0] v, input logic [WIDTH-1:0] d);
    exp_t e;
    e.vc   = v;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock: score a pop (if any) before the edge, then the credit after it.
  task automatic tick();
    logic            pop_now;
    logic [VC_W-1:0] cvc;
    exp_t            e;
    pop_now = shift && read_valid_o && !rst;
    cvc     = '0;
    if (shift && !read_valid_o && !rst) begin
      checks++;
      errors++;
      $display("FAIL protocol: shift=1 driven while read_valid_o=%b", read_valid_o);
    end
    if (pop_now) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got vc=%0d data=%h, no flit expected", vc_o, data_o);
      end else begin
        e   = exp_q.pop_front();
        cvc = e.vc;
        if (data_o !== e.data || vc_o !== e.vc) begin
          errors++;
          $display("FAIL pop_flit: got vc=%0d data=%h, expected vc=%0d data=%h",
                   vc_o, data_o, e.vc, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (pop_now) begin
      if (credit_valid_o !== 1'b1 || credit_vc_o !== cvc) begin
        errors++;
        $display("FAIL credit: got valid=%b vc=%0d, expected valid=1 vc=%0d",
                 credit_valid_o, credit_vc_o, cvc);
      end
    end else if (credit_valid_o !== 1'b0 || credit_vc_o !== '0) begin
      errors++;
      $display("FAIL no_credit: got valid=%b vc=%0d, expected valid=0 vc=0",
               credit_valid_o, credit_vc_o);
    end
  endtask

  task automatic write_flit(input logic [VC_W-1:0] v, input logic [WIDTH-1:0] d);
    write_en = 1'b1;
    vc_i     = v;
    data_i   = d;
    tick();
    write_en = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    write_en = 1'b0;
    shift    = 1'b0;
    vc_i     = '0;
    data_i   = '0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (read_valid_o !== 1'b0 || data_o !== '0 || vc_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b data=%h vc=%0d, expected 0/0/0",
               read_valid_o, data_o, vc_o);
    end
    checks++;
    if (count_o !== '0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got count=%h ovf=%b, expected 0/0", count_o, overflow_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) write_flit(1'b0, WIDTH'(i));
    checks++;
    if (cnt(0) !== 3'd5 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL full_vc0: got count=%0d ovf=%b, expected 5/0", cnt(0), overflow_o);
    end
    write_flit(1'b0, 16'h0006);
    checks++;
    if (cnt(0) !== 3'd5 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got count=%0d ovf=%b, expected 5/1", cnt(0), overflow_o);
    end
    shift = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      expect_flit(1'b0, WIDTH'(i));
      tick();
    end
    shift = 1'b0;
    checks++;
    if (read_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL drained_sticky: got rv=%b ovf=%b, expected 0/1", read_valid_o, overflow_o);
    end
  endtask

  task automatic test_latency();
    do_reset();
    write_flit(1'b0, 16'h00A1);
    checks++;
    if (read_valid_o !== 1'b1 || data_o !== 16'h00A1 || vc_o !== 1'b0) begin
      errors++;
      $display("FAIL first_word: got rv=%b data=%h vc=%0d, expected 1/00a1/0",
               read_valid_o, data_o, vc_o);
    end
    shift = 1'b1;
    expect_flit(1'b0, 16'h00A1);
    tick();
    shift = 1'b0;
    checks++;
    if (read_valid_o !== 1'b0 || data_o !== '0 || vc_o !== '0) begin
      errors++;
      $display("FAIL after_pop: got rv=%b data=%h vc=%0d, expected 0/0/0",
               read_valid_o, data_o, vc_o);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    write_flit(1'b0, 16'h0010);
    write_flit(1'b0, 16'h0011);
    write_flit(1'b1, 16'h0020);
    write_flit(1'b1, 16'h0021);
    checks++;
    if (cnt(0) !== 3'd2 || cnt(1) !== 3'd2) begin
      errors++;
      $display("FAIL preload: got count0=%0d count1=%0d, expected 2/2", cnt(0), cnt(1));
    end
    expect_flit(1'b0, 16'h0010);
    expect_flit(1'b1, 16'h0020);
    expect_flit(1'b0, 16'h0011);
    expect_flit(1'b1, 16'h0021);
    shift = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    shift = 1'b0;
    checks++;
    if (read_valid_o !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: got rv=%b pending=%0d, expected 0/0", read_valid_o, exp_q.size());
    end
  endtask

  task automatic test_lock();
    do_reset();
    // One pop on VC0 moves the round-robin pointer to VC1.
    write_flit(1'b0, 16'h002F);
    shift = 1'b1;
    expect_flit(1'b0, 16'h002F);
    tick();
    shift = 1'b0;
    write_flit(1'b0, 16'h0030);
    write_flit(1'b1, 16'h0040);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (data_o !== 16'h0030 || vc_o !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold: got data=%h vc=%0d, expected 0030/0", data_o, vc_o);
      end
      if (i < 2) tick();
    end
    shift = 1'b1;
    expect_flit(1'b0, 16'h0030);
    tick();
    checks++;
    if (data_o !== 16'h0040 || vc_o !== 1'b1) begin
      errors++;
      $display("FAIL after_lock: got data=%h vc=%0d, expected 0040/1", data_o, vc_o);
    end
    expect_flit(1'b1, 16'h0040);
    tick();
    shift = 1'b0;
    checks++;
    if (read_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL lock_drain: got rv=%b, expected 0", read_valid_o);
    end
  endtask

  task automatic test_full_write_pop();
    do_reset();
    for (int i = 0; i < 5; i++) write_flit(1'b0, 16'h0050 + WIDTH'(i));
    checks++;
    if (cnt(0) !== 3'd5 || data_o !== 16'h0050) begin
      errors++;
      $display("FAIL full_head: got count=%0d data=%h, expected 5/0050", cnt(0), data_o);
    end
    write_en = 1'b1;
    vc_i     = 1'b0;
    data_i   = 16'h0055;
    shift    = 1'b1;
    expect_flit(1'b0, 16'h0050);
    tick();
    write_en = 1'b0;
    checks++;
    if (cnt(0) !== 3'd5 || overflow_o !== 1'b0 || data_o !== 16'h0051) begin
      errors++;
      $display("FAIL full_wr_pop: got count=%0d ovf=%b data=%h, expected 5/0/0051",
               cnt(0), overflow_o, data_o);
    end
    for (int i = 1; i <= 5; i++) begin
      expect_flit(1'b0, 16'h0050 + WIDTH'(i));
      tick();
    end
    shift = 1'b0;
    checks++;
    if (cnt(0) !== 3'd0 || read_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: got count=%0d rv=%b, expected 0/0", cnt(0), read_valid_o);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) write_flit(1'b0, 16'h0061 + WIDTH'(i));
    for (int i = 0; i < 6; i++) write_flit(1'b1, 16'h0070 + WIDTH'(i));
    checks++;
    if (cnt(0) !== 3'd3 || cnt(1) !== 3'd5 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got count0=%0d count1=%0d ovf=%b, expected 3/5/1",
               cnt(0), cnt(1), overflow_o);
    end
    rst      = 1'b1;
    write_en = 1'b1;
    vc_i     = 1'b0;
    data_i   = 16'h006F;
    shift    = 1'b1;
    tick();
    rst      = 1'b0;
    write_en = 1'b0;
    shift    = 1'b0;
    checks++;
    if (count_o !== '0 || read_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got count=%h rv=%b ovf=%b, expected 0/0/0",
               count_o, read_valid_o, overflow_o);
    end
    checks++;
    if (data_o !== '0 || vc_o !== '0) begin
      errors++;
      $display("FAIL mid_reset_out: got data=%h vc=%0d, expected 0/0", data_o, vc_o);
    end
    tick();
    checks++;
    if (count_o !== '0 || read_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_write_kept: got count=%h rv=%b, expected 0/0", count_o, read_valid_o);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    write_en = 1'b0;
    shift    = 1'b0;
    vc_i     = '0;
    data_i   = '0;
    test_reset();
    test_overflow();
    test_latency();
    test_round_robin();
    test_lock();
    test_full_write_pop();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
